// File: rtl/axi_typedef_pkg.sv
// rtl/axi_typedef_pkg.sv - shared AXI4 field types, response/burst codes and FSM state types
package axi_typedef_pkg;

  typedef logic [7:0] len_t;
  typedef logic [2:0] size_t;
  typedef logic [1:0] burst_t;
  typedef logic [3:0] cache_t;
  typedef logic [2:0] prot_t;
  typedef logic [3:0] qos_t;
  typedef logic [3:0] region_t;
  typedef logic [5:0] atop_t;
  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_DATA} rd_state_t;

  // A decode error on a beat outranks a slave error for the same burst.
  function automatic resp_t beat_resp(input logic slv, input logic dec);
    return dec ? RESP_DECERR : (slv ? RESP_SLVERR : RESP_OKAY);
  endfunction

endpackage

// File: rtl/axi_beat_addr.sv
// rtl/axi_beat_addr.sv - next beat address for FIXED, INCR and WRAP bursts
module axi_beat_addr
  import axi_typedef_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  size_t                 size,
  input  len_t                  len,
  input  burst_t                burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  assign step      = ADDR_WIDTH'(1) << size;
  assign incr      = addr + step;
  // Wrap length (len+1)*2**size is a power of two for every legal WRAP burst.
  assign wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);

  always_comb begin
    next_addr = incr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi_modport.sv
// rtl/axi_modport.sv - AXI4 slave memory with independent write and read FSMs
module axi_modport
  import axi_typedef_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 1,
  parameter int MEM_WORDS      = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
  input  len_t                        aw_len,
  input  size_t                       aw_size,
  input  burst_t                      aw_burst,
  input  logic                        aw_lock,
  input  cache_t                      aw_cache,
  input  prot_t                       aw_prot,
  input  qos_t                        aw_qos,
  input  region_t                     aw_region,
  input  atop_t                       aw_atop,
  input  logic [AXI_USER_WIDTH-1:0]   aw_user,
  input  logic                        aw_valid,
  output logic                        aw_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
  input  logic                        w_last,
  input  logic [AXI_USER_WIDTH-1:0]   w_user,
  input  logic                        w_valid,
  output logic                        w_ready,
  output logic [AXI_ID_WIDTH-1:0]     b_id,
  output resp_t                       b_resp,
  output logic [AXI_USER_WIDTH-1:0]   b_user,
  output logic                        b_valid,
  input  logic                        b_ready,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
  input  len_t                        ar_len,
  input  size_t                       ar_size,
  input  burst_t                      ar_burst,
  input  logic                        ar_lock,
  input  cache_t                      ar_cache,
  input  prot_t                       ar_prot,
  input  qos_t                        ar_qos,
  input  region_t                     ar_region,
  input  logic [AXI_USER_WIDTH-1:0]   ar_user,
  input  logic                        ar_valid,
  output logic                        ar_ready,
  output logic [AXI_ID_WIDTH-1:0]     r_id,
  output logic [AXI_DATA_WIDTH-1:0]   r_data,
  output resp_t                       r_resp,
  output logic                        r_last,
  output logic [AXI_USER_WIDTH-1:0]   r_user,
  output logic                        r_valid,
  input  logic                        r_ready
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam size_t SIZE_MAX = size_t'(OFFS);
  localparam logic [AXI_ADDR_WIDTH-1:0] WORDS = AXI_ADDR_WIDTH'(MEM_WORDS);

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic unused_sideband;
  assign unused_sideband = ^{aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_user, w_user,
                             ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user};

  assign b_user = '0;
  assign r_user = '0;

  wr_state_t                 wr_state;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr, wr_next, wr_idx;
  len_t                      wr_len;
  size_t                     wr_size;
  burst_t                    wr_burst;
  logic                      wr_slv, wr_dec, wr_hit, w_fire, mem_we;

  assign wr_idx = wr_addr >> OFFS;
  assign wr_hit = wr_idx < WORDS;
  assign w_fire = w_valid && w_ready;
  assign mem_we = w_fire && wr_hit && !wr_slv;

  axi_beat_addr #(.ADDR_WIDTH(AXI_ADDR_WIDTH)) u_wr_step (
    .addr(wr_addr), .size(wr_size), .len(wr_len), .burst(wr_burst), .next_addr(wr_next)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb[i]) mem[wr_idx[IDX_W-1:0]][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_IDLE;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_id     <= '0;
      b_resp   <= RESP_OKAY;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_size  <= '0;
      wr_burst <= BURST_FIXED;
      wr_slv   <= 1'b0;
      wr_dec   <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          aw_ready <= 1'b1;
          if (aw_valid && aw_ready) begin
            aw_ready <= 1'b0;
            w_ready  <= 1'b1;
            b_id     <= aw_id;
            wr_addr  <= aw_addr;
            wr_len   <= aw_len;
            wr_size  <= aw_size;
            wr_burst <= aw_burst;
            wr_slv   <= (aw_atop != '0) || (aw_size > SIZE_MAX) || (aw_burst == 2'b11);
            wr_dec   <= 1'b0;
            wr_state <= WR_DATA;
          end
        end
        WR_DATA: begin
          // w_last alone closes the burst; the beat count against len is not enforced.
          if (w_fire) begin
            wr_addr <= wr_next;
            if (!wr_hit) wr_dec <= 1'b1;
            if (w_last) begin
              w_ready  <= 1'b0;
              b_valid  <= 1'b1;
              b_resp   <= beat_resp(wr_slv, wr_dec || !wr_hit);
              wr_state <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (b_ready) begin
            b_valid  <= 1'b0;
            aw_ready <= 1'b1;
            wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  rd_state_t                 rd_state;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr, rd_next, src_addr, src_idx;
  len_t                      rd_len, rd_beat;
  size_t                     rd_size;
  burst_t                    rd_burst;
  logic                      rd_slv, src_slv, src_hit, ar_fire, r_fire;

  axi_beat_addr #(.ADDR_WIDTH(AXI_ADDR_WIDTH)) u_rd_step (
    .addr(rd_addr), .size(rd_size), .len(rd_len), .burst(rd_burst), .next_addr(rd_next)
  );

  // Beat source: the AR address for the first beat, the stepped address afterwards.
  assign ar_fire  = ar_valid && ar_ready;
  assign r_fire   = r_valid && r_ready;
  assign src_addr = (rd_state == RD_IDLE) ? ar_addr : rd_next;
  assign src_slv  = (rd_state == RD_IDLE) ? ((ar_size > SIZE_MAX) || (ar_burst == 2'b11)) : rd_slv;
  assign src_idx  = src_addr >> OFFS;
  assign src_hit  = src_idx < WORDS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_id     <= '0;
      r_data   <= '0;
      r_resp   <= RESP_OKAY;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_beat  <= '0;
      rd_size  <= '0;
      rd_burst <= BURST_FIXED;
      rd_slv   <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          ar_ready <= 1'b1;
          if (ar_fire) begin
            ar_ready <= 1'b0;
            r_valid  <= 1'b1;
            r_id     <= ar_id;
            rd_addr  <= ar_addr;
            rd_len   <= ar_len;
            rd_size  <= ar_size;
            rd_burst <= ar_burst;
            rd_slv   <= src_slv;
            rd_beat  <= '0;
            r_last   <= (ar_len == '0);
            r_resp   <= beat_resp(src_slv, !src_hit);
            r_data   <= (src_slv || !src_hit) ? '0 : mem[src_idx[IDX_W-1:0]];
            rd_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_fire) begin
            if (r_last) begin
              r_valid  <= 1'b0;
              r_last   <= 1'b0;
              ar_ready <= 1'b1;
              rd_state <= RD_IDLE;
            end else begin
              rd_addr <= rd_next;
              rd_beat <= rd_beat + 8'd1;
              r_last  <= (rd_beat + 8'd1 == rd_len);
              r_resp  <= beat_resp(src_slv, !src_hit);
              r_data  <= (src_slv || !src_hit) ? '0 : mem[src_idx[IDX_W-1:0]];
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_modport.sv
// tb/tb_axi_modport.sv - randomized scoreboard bench for the AXI4 slave memory
module tb_axi_modport;
  import axi_typedef_pkg::*;

  localparam int AW = 32, DW = 64, IW = 4, UW = 1, WORDS = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [IW-1:0] aw_id;  logic [AW-1:0] aw_addr; len_t aw_len; size_t aw_size; burst_t aw_burst;
  logic aw_lock; cache_t aw_cache; prot_t aw_prot; qos_t aw_qos; region_t aw_region; atop_t aw_atop;
  logic [UW-1:0] aw_user; logic aw_valid, aw_ready;
  logic [DW-1:0] w_data; logic [DW/8-1:0] w_strb; logic w_last; logic [UW-1:0] w_user; logic w_valid, w_ready;
  logic [IW-1:0] b_id; resp_t b_resp; logic [UW-1:0] b_user; logic b_valid, b_ready;
  logic [IW-1:0] ar_id;  logic [AW-1:0] ar_addr; len_t ar_len; size_t ar_size; burst_t ar_burst;
  logic ar_lock; cache_t ar_cache; prot_t ar_prot; qos_t ar_qos; region_t ar_region;
  logic [UW-1:0] ar_user; logic ar_valid, ar_ready;
  logic [IW-1:0] r_id; logic [DW-1:0] r_data; resp_t r_resp; logic r_last; logic [UW-1:0] r_user;
  logic r_valid, r_ready;

  axi_modport #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
                .AXI_USER_WIDTH(UW), .MEM_WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_prot(aw_prot), .aw_qos(aw_qos),
    .aw_region(aw_region), .aw_atop(aw_atop), .aw_user(aw_user), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(w_user), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot), .ar_qos(ar_qos),
    .ar_region(ar_region), .ar_user(ar_user), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
    .r_valid(r_valid), .r_ready(r_ready)
  );

  typedef struct { logic [IW-1:0] id; resp_t resp; } b_exp_t;
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; resp_t resp; logic last; } r_exp_t;

  b_exp_t exp_b[$];
  r_exp_t exp_r[$];
  logic [DW-1:0] ref_mem [WORDS];
  logic [DW-1:0] wd [256];
  logic [7:0]    ws [256];
  int checks = 0;
  int errors = 0;
  int rr_mode = 0;  // 0 random readies, 1 r_ready toggling, 2 readies held high

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Byte address of beat i, straight from the AXI burst definitions.
  function automatic longint model_addr(input longint start, input int sz, input int ln, input int bu, input int i);
    longint nb, wsz, lower;
    nb = longint'(1) << sz;
    wsz = longint'(ln + 1) * nb;
    if (bu == 0) return start;
    if (bu == 2) begin
      lower = (start / wsz) * wsz;
      return lower + ((start - lower + longint'(i) * nb) % wsz);
    end
    return start + longint'(i) * nb;
  endfunction

  task automatic fill_random(input int n, input bit full);
    for (int i = 0; i < n; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = full ? 8'hFF : 8'($urandom);
    end
  endtask

  task automatic wait_ready(input int ch, input string nm);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if ((ch == 0 && aw_ready) || (ch == 1 && w_ready) || (ch == 2 && ar_ready)) break;
      n++;
      if (n > 2000) begin
        checks++; errors++;
        $display("FAIL timeout_%s actual=no_ready required=ready", nm);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int ln,
                          input int sz, input int bu, input logic [5:0] atop, input int sent_beats);
    bit slv, dec;
    int n, sent;
    longint a, widx;
    b_exp_t e;
    slv = (atop != 0) || (sz > 3) || (bu == 3);
    dec = 0;
    n = ln + 1;
    sent = (sent_beats < 0) ? n : sent_beats;
    for (int i = 0; i < n; i++) begin
      a = model_addr(longint'(addr), sz, ln, bu, i);
      widx = a / 8;
      if (widx >= WORDS) dec = 1;
      else if (!slv && i < sent)
        for (int k = 0; k < 8; k++) if (ws[i][k]) ref_mem[int'(widx)][8*k +: 8] = wd[i][8*k +: 8];
    end
    if (sent_beats < 0) begin
      e.id = id;
      e.resp = dec ? RESP_DECERR : (slv ? RESP_SLVERR : RESP_OKAY);
      exp_b.push_back(e);
    end
    aw_id = id; aw_addr = addr; aw_len = len_t'(ln); aw_size = size_t'(sz); aw_burst = burst_t'(bu);
    aw_atop = atop; aw_lock = 1'($urandom); aw_cache = 4'($urandom); aw_prot = 3'($urandom);
    aw_qos = 4'($urandom); aw_region = 4'($urandom); aw_user = UW'($urandom);
    aw_valid = 1'b1;
    wait_ready(0, "aw");
    aw_valid = 1'b0;
    for (int i = 0; i < sent; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      w_data = wd[i]; w_strb = ws[i]; w_last = (i == ln); w_user = UW'($urandom);
      w_valid = 1'b1;
      wait_ready(1, "w");
      w_valid = 1'b0;
    end
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int ln,
                         input int sz, input int bu);
    bit slv;
    longint a, widx;
    r_exp_t e;
    slv = (sz > 3) || (bu == 3);
    for (int i = 0; i <= ln; i++) begin
      a = model_addr(longint'(addr), sz, ln, bu, i);
      widx = a / 8;
      e.id = id;
      e.resp = (widx >= WORDS) ? RESP_DECERR : (slv ? RESP_SLVERR : RESP_OKAY);
      e.data = (e.resp != RESP_OKAY) ? '0 : ref_mem[int'(widx)];
      e.last = (i == ln);
      exp_r.push_back(e);
    end
    ar_id = id; ar_addr = addr; ar_len = len_t'(ln); ar_size = size_t'(sz); ar_burst = burst_t'(bu);
    ar_lock = 1'($urandom); ar_cache = 4'($urandom); ar_prot = 3'($urandom);
    ar_qos = 4'($urandom); ar_region = 4'($urandom); ar_user = UW'($urandom);
    ar_valid = 1'b1;
    wait_ready(2, "ar");
    ar_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (exp_r.size() != 0 || exp_b.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout_drain actual=%0d pending required=0", exp_r.size() + exp_b.size());
      exp_r.delete(); exp_b.delete();
    end
    #1;
  endtask

  initial begin
    b_ready = 1'b0;
    r_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0: begin b_ready = ($urandom_range(0, 3) != 0); r_ready = ($urandom_range(0, 3) != 0); end
        1: begin b_ready = 1'b1; r_ready = ~r_ready; end
        default: begin b_ready = 1'b1; r_ready = 1'b1; end
      endcase
    end
  end

  bit stall_r = 0, stall_b = 0, flow_r = 0;
  logic [DW-1:0] hd;
  logic [IW+2:0] hr_ctl;
  logic [IW+1:0] hb_ctl;

  initial begin
    b_exp_t eb;
    r_exp_t er;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_r = 0; stall_b = 0; flow_r = 0;
      end else begin
        if (stall_r) begin
          check("r_hold_valid", 64'(r_valid), 64'd1);
          check("r_hold_data", r_data, hd);
          check("r_hold_ctl", 64'({r_last, r_resp, r_id}), 64'(hr_ctl));
        end
        if (stall_b) check("b_hold", 64'({b_valid, b_id, b_resp}), 64'({1'b1, hb_ctl}));
        if (flow_r && rr_mode == 2) check("r_no_bubble", 64'(r_valid), 64'd1);
        if (b_valid && b_ready) begin
          if (exp_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_b actual id=%0d resp=%0d required=no_response", b_id, b_resp);
          end else begin
            eb = exp_b.pop_front();
            check("b_id", 64'(b_id), 64'(eb.id));
            check("b_resp", 64'(b_resp), 64'(eb.resp));
            check("b_user", 64'(b_user), 64'd0);
          end
        end
        if (r_valid && r_ready) begin
          if (exp_r.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_r actual id=%0d data=%0h required=no_beat", r_id, r_data);
          end else begin
            er = exp_r.pop_front();
            check("r_id", 64'(r_id), 64'(er.id));
            check("r_data", r_data, er.data);
            check("r_resp", 64'(r_resp), 64'(er.resp));
            check("r_last", 64'(r_last), 64'(er.last));
            check("r_user", 64'(r_user), 64'd0);
          end
        end
        stall_r = r_valid && !r_ready;
        hd = r_data;
        hr_ctl = {r_last, r_resp, r_id};
        stall_b = b_valid && !b_ready;
        hb_ctl = {b_id, b_resp};
        flow_r = r_valid && r_ready && !r_last;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int sz, bu, ln, word;
    logic [AW-1:0] addr;
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_lock = 0; aw_cache = '0;
    aw_prot = '0; aw_qos = '0; aw_region = '0; aw_atop = '0; aw_user = '0;
    w_data = '0; w_strb = '0; w_last = 0; w_user = '0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_lock = 0; ar_cache = '0;
    ar_prot = '0; ar_qos = '0; ar_region = '0; ar_user = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", 64'({aw_ready, w_ready, ar_ready, b_valid, r_valid, r_last}), 64'd0);
    check("rst_fields", 64'({b_id, b_resp, r_id, r_resp, b_user, r_user}), 64'd0);
    check("rst_r_data", r_data, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("ready_after_rst", 64'({aw_ready, ar_ready}), 64'd3);
    @(posedge clk); #1;

    rr_mode = 2;
    for (int k = 0; k < 4; k++) begin
      fill_random(256, 1);
      do_write(IW'(k), AW'(k * 256 * 8), 255, 3, 1, '0, -1);
    end
    drain();

    rr_mode = 0;
    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    do_write(4'd5, 32'h0, 3, 3, 1, '0, -1);
    do_read(4'd9, 32'h0, 3, 3, 1);
    drain();

    wd[0] = '1; ws[0] = 8'hFF;
    do_write(4'd1, 32'h8, 0, 3, 1, '0, -1);
    wd[0] = '0; ws[0] = 8'h0F;
    do_write(4'd1, 32'h8, 0, 3, 1, '0, -1);
    do_read(4'd2, 32'h8, 0, 3, 1);
    drain();

    do_read(4'd3, 32'h18, 3, 3, 2);
    drain();

    fill_random(4, 1);
    do_write(4'd4, AW'(WORDS * 8), 0, 3, 1, '0, -1);
    do_read(4'd4, AW'(WORDS * 8), 0, 3, 1);
    drain();
    fill_random(4, 0);
    do_write(4'd6, AW'((WORDS - 2) * 8), 3, 3, 1, '0, -1);
    do_read(4'd7, AW'((WORDS - 2) * 8), 3, 3, 1);
    do_write(4'd6, AW'(WORDS * 8), 0, 3, 1, 6'h1, -1);
    drain();

    fill_random(4, 1);
    do_write(4'd8, 32'h40, 1, 3, 1, 6'h1, -1);
    do_write(4'd8, 32'h40, 0, 4, 1, '0, -1);
    do_write(4'd8, 32'h40, 1, 3, 3, '0, -1);
    do_read(4'd8, 32'h40, 1, 3, 3);
    drain();
    do_read(4'd8, 32'h40, 1, 4, 1);
    drain();
    do_read(4'd8, 32'h40, 1, 3, 1);
    drain();

    fill_random(4, 0);
    do_write(4'd10, 32'h80, 3, 3, 0, '0, -1);
    do_read(4'd10, 32'h80, 3, 3, 0);
    drain();
    fill_random(4, 0);
    do_write(4'd11, 32'h104, 3, 2, 1, '0, -1);
    do_read(4'd11, 32'h100, 1, 3, 1);
    drain();

    rr_mode = 1;
    do_read(4'd12, 32'h200, 7, 3, 1);
    drain();
    rr_mode = 2;
    do_read(4'd13, 32'h300, 7, 3, 1);
    drain();
    rr_mode = 0;

    fill_random(4, 1);
    do_write(4'd14, 32'h400, 3, 3, 1, '0, 2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", 64'({aw_ready, w_ready, ar_ready, b_valid, r_valid, r_last}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("aw_ready_after_abort", 64'(aw_ready), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    do_read(4'd15, 32'h400, 3, 3, 1);
    drain();

    for (int t = 0; t < 40; t++) begin
      sz = $urandom_range(0, 3);
      bu = $urandom_range(0, 2);
      word = $urandom_range(0, 1030);
      if (bu == 2) ln = (1 << $urandom_range(1, 3)) - 1;
      else ln = $urandom_range(0, 7);
      addr = AW'(word * 8 + (int'($urandom_range(0, 7)) & ~((1 << sz) - 1)));
      if ($urandom_range(0, 1) == 1) begin
        fill_random(ln + 1, 0);
        do_write(IW'($urandom), addr, ln, sz, bu, '0, -1);
      end else begin
        do_read(IW'($urandom), addr, ln, sz, bu);
        drain();
      end
    end
    drain();
    check("scoreboard_empty", 64'(exp_b.size() + exp_r.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
